branch_history_predictor: RTL and testbench

//  Parametrised dynamic successor to the static not-taken predictor in the MIPS fetch/decode path.

---
 rtl/branch_history_predictor_pkg.sv | 36 +++
 rtl/branch_history_predictor_sat_counter.sv | 36 +++
 rtl/branch_history_predictor.sv | 119 +++++++++++
 tb/tb_branch_history_predictor.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_history_predictor_pkg.sv
// Shared decode constants and mode encodings for the MIPS branch predictor.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package branch_history_predictor_pkg;

    // Primary opcodes, instruction bits [31:26]
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    // REGIMM rt codes, instruction bits [20:16]
    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    // Prediction mode; any value with bit 1 set selects the dynamic table
    localparam logic [1:0] MODE_NT  = 2'b00;
    localparam logic [1:0] MODE_T   = 2'b01;
    localparam logic [1:0] MODE_DYN = 2'b10;

    function automatic logic is_cond_branch(input logic [5:0] op, input logic [4:0] rt);
        logic hit;
        hit = 1'b0;
        case (op)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: hit = 1'b1;
            OP_REGIMM: hit = (rt == RT_BLTZ) || (rt == RT_BGEZ) ||
                             (rt == RT_BLTZAL) || (rt == RT_BGEZAL);
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/branch_history_predictor_sat_counter.sv
// Saturating up/down counter; inc and dec together (or neither) hold the value.
// Latency: count updates on the clock edge; count_next shows the value about to be loaded.
// Backpressure: none.
// Ports: core_clk, arst_n (async active-low), inc, dec, count (registered), count_next (comb).
module sat_counter #(
    parameter int         W    = 2,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         core_clk,
    input  logic         arst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next
);

    localparam logic [W-1:0] MAX_VAL = '1;

    always_comb begin
        count_next = count;
        if (inc && !dec && (count != MAX_VAL)) begin
            count_next = count + W'(1);
        end else if (dec && !inc && (count != '0)) begin
            count_next = count - W'(1);
        end
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            count <= INIT;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/branch_history_predictor.sv
// PC-indexed saturating-counter branch predictor with static comparison modes.
// Latency: 1 cycle from Instr_* sample to Taken/Taken_valid.
// Backpressure: Stall holds the prediction outputs; training from execute never stalls.
// Ports: CLK, RESET (async active-low); fetch Instr_valid/Instr_input/Instr_addr_input;
//        Stall, Mode; execute feedback Branch_resolved*/Branch_mispredict;
//        outputs Taken, Taken_valid, Predict_count, Mispredict_count.
module branch_history_predictor
    import branch_history_predictor_pkg::*;
#(
    parameter int ENTRIES  = 64,
    parameter int CTR_BITS = 2,
    parameter int CTR_INIT = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        Instr_valid,
    input  logic [31:0] Instr_input,
    input  logic [31:0] Instr_addr_input,
    input  logic        Stall,
    input  logic [1:0]  Mode,
    input  logic        Branch_resolved,
    input  logic [31:0] Branch_resolved_addr,
    input  logic        Branch_resolved_taken,
    input  logic        Branch_mispredict,
    output logic        Taken,
    output logic        Taken_valid,
    output logic [31:0] Predict_count,
    output logic [31:0] Mispredict_count
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [IDX_W-1:0]    lkp_idx;
    logic [IDX_W-1:0]    upd_idx;
    logic                is_branch;
    logic                sample_branch;
    logic [CTR_BITS-1:0] ctr_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d [ENTRIES];
    logic [CTR_BITS-1:0] lookup_ctr;
    logic                next_taken;
    logic [31:0]         pc_next_unused;
    logic [31:0]         mc_next_unused;
    logic                unused_bits;

    // Word-aligned PCs: drop the byte offset before indexing
    assign lkp_idx = Instr_addr_input[IDX_W+1:2];
    assign upd_idx = Branch_resolved_addr[IDX_W+1:2];

    assign is_branch     = is_cond_branch(Instr_input[31:26], Instr_input[20:16]);
    assign sample_branch = !Stall && Instr_valid && is_branch;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
        logic hit;
        assign hit = Branch_resolved && (upd_idx == IDX_W'(i));
        sat_counter #(
            .W    (CTR_BITS),
            .INIT (CTR_BITS'(CTR_INIT))
        ) u_ctr (
            .core_clk   (CLK),
            .arst_n     (RESET),
            .inc        (hit && Branch_resolved_taken),
            .dec        (hit && !Branch_resolved_taken),
            .count      (ctr_q[i]),
            .count_next (ctr_d[i])
        );
    end

    // Bypass: a lookup that collides with this cycle's training sees the trained value
    always_comb begin
        lookup_ctr = ctr_q[lkp_idx];
        if (Branch_resolved && (upd_idx == lkp_idx)) begin
            lookup_ctr = ctr_d[upd_idx];
        end
    end

    always_comb begin
        next_taken = 1'b0;
        if (Mode[1]) begin
            next_taken = lookup_ctr[CTR_BITS-1];
        end else if (Mode == MODE_T) begin
            next_taken = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Taken       <= 1'b0;
            Taken_valid <= 1'b0;
        end else if (!Stall) begin
            Taken_valid <= sample_branch;
            Taken       <= sample_branch && next_taken;
        end
    end

    sat_counter #(.W(32), .INIT(32'd0)) u_predict_count (
        .core_clk   (CLK),
        .arst_n     (RESET),
        .inc        (sample_branch),
        .dec        (1'b0),
        .count      (Predict_count),
        .count_next (pc_next_unused)
    );

    sat_counter #(.W(32), .INIT(32'd0)) u_mispredict_count (
        .core_clk   (CLK),
        .arst_n     (RESET),
        .inc        (Branch_resolved && Branch_mispredict),
        .dec        (1'b0),
        .count      (Mispredict_count),
        .count_next (mc_next_unused)
    );

    // Fields the predictor never looks at (rs, immediate, upper PC bits)
    assign unused_bits = ^{Instr_input[25:21], Instr_input[15:0],
                           Instr_addr_input[31:IDX_W+2], Instr_addr_input[1:0],
                           Branch_resolved_addr[31:IDX_W+2], Branch_resolved_addr[1:0],
                           pc_next_unused, mc_next_unused};

endmodule

// File: tb/tb_branch_history_predictor.sv
module tb_branch_history_predictor;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        Instr_valid = 1'b0;
    logic [31:0] Instr_input = '0;
    logic [31:0] Instr_addr_input = '0;
    logic        Stall = 1'b0;
    logic [1:0]  Mode = 2'b10;
    logic        Branch_resolved = 1'b0;
    logic [31:0] Branch_resolved_addr = '0;
    logic        Branch_resolved_taken = 1'b0;
    logic        Branch_mispredict = 1'b0;
    logic        Taken;
    logic        Taken_valid;
    logic [31:0] Predict_count;
    logic [31:0] Mispredict_count;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    localparam logic [31:0] I_BEQ  = 32'h1085_0004;
    localparam logic [31:0] I_BNE  = 32'h1485_0004;
    localparam logic [31:0] I_BLEZ = 32'h1880_0004;
    localparam logic [31:0] I_BGTZ = 32'h1C80_0004;
    localparam logic [31:0] I_ADD  = 32'h0085_1020;

    branch_history_predictor dut (
        .CLK                   (CLK),
        .RESET                 (RESET),
        .Instr_valid           (Instr_valid),
        .Instr_input           (Instr_input),
        .Instr_addr_input      (Instr_addr_input),
        .Stall                 (Stall),
        .Mode                  (Mode),
        .Branch_resolved       (Branch_resolved),
        .Branch_resolved_addr  (Branch_resolved_addr),
        .Branch_resolved_taken (Branch_resolved_taken),
        .Branch_mispredict     (Branch_mispredict),
        .Taken                 (Taken),
        .Taken_valid           (Taken_valid),
        .Predict_count         (Predict_count),
        .Mispredict_count      (Mispredict_count)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    int      m_ctr [64];
    bit      m_taken, m_valid;
    longint  m_pc, m_mc;

    function automatic bit model_is_branch(logic [31:0] w);
        int op, rt;
        op = int'(w[31:26]);
        rt = int'(w[20:16]);
        if (op >= 4 && op <= 7) return 1'b1;
        if (op == 1 && (rt == 0 || rt == 1 || rt == 16 || rt == 17)) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 64; i++) m_ctr[i] = 1;
            m_taken = 0; m_valid = 0; m_pc = 0; m_mc = 0;
        end else begin
            int ri, li;
            bit br;
            ri = int'((Branch_resolved_addr / 4) % 64);
            li = int'((Instr_addr_input / 4) % 64);
            if (Branch_resolved) begin
                if (Branch_resolved_taken) m_ctr[ri] = (m_ctr[ri] < 3) ? m_ctr[ri] + 1 : 3;
                else                       m_ctr[ri] = (m_ctr[ri] > 0) ? m_ctr[ri] - 1 : 0;
                if (Branch_mispredict && m_mc < 64'hFFFF_FFFF) m_mc++;
            end
            if (!Stall) begin
                br = Instr_valid && model_is_branch(Instr_input);
                m_valid = br;
                if (!br)              m_taken = 0;
                else if (Mode >= 2)   m_taken = (m_ctr[li] >= 2);
                else                  m_taken = (Mode == 2'b01);
                if (br && m_pc < 64'hFFFF_FFFF) m_pc++;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            n_chk++;
            if (Taken !== m_taken || Taken_valid !== m_valid ||
                Predict_count !== 32'(m_pc) || Mispredict_count !== 32'(m_mc)) begin
                n_err++;
                $display("FAIL model t=%0t got T=%b V=%b P=%0d M=%0d want T=%b V=%b P=%0d M=%0d",
                         $time, Taken, Taken_valid, Predict_count, Mispredict_count,
                         m_taken, m_valid, m_pc, m_mc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input bit v, input logic [31:0] ins, input logic [31:0] addr,
                       input bit stl, input logic [1:0] md,
                       input bit res, input logic [31:0] raddr, input bit rtk, input bit mis);
        @(negedge CLK);
        Instr_valid = v; Instr_input = ins; Instr_addr_input = addr;
        Stall = stl; Mode = md;
        Branch_resolved = res; Branch_resolved_addr = raddr;
        Branch_resolved_taken = rtk; Branch_mispredict = mis;
        @(posedge CLK);
        #1;
    endtask

    task automatic fetch(input logic [31:0] ins, input logic [31:0] addr, input logic [1:0] md);
        cyc(1, ins, addr, 0, md, 0, 0, 0, 0);
    endtask

    task automatic resolve(input logic [31:0] raddr, input bit tk, input bit mis);
        cyc(0, I_ADD, 0, 0, 2'b10, 1, raddr, tk, mis);
    endtask

    logic [31:0] dec_ins [8];
    bit          dec_exp [8];

    initial begin
        dec_ins[0] = 32'h0480_0004; dec_exp[0] = 1;  // BLTZ
        dec_ins[1] = 32'h0481_0004; dec_exp[1] = 1;  // BGEZ
        dec_ins[2] = 32'h0490_0004; dec_exp[2] = 1;  // BLTZAL
        dec_ins[3] = 32'h0491_0004; dec_exp[3] = 1;  // BGEZAL
        dec_ins[4] = I_BLEZ;        dec_exp[4] = 1;
        dec_ins[5] = 32'h0482_0004; dec_exp[5] = 0;  // REGIMM rt=2
        dec_ins[6] = 32'h0800_0100; dec_exp[6] = 0;  // J
        dec_ins[7] = 32'h0080_0008; dec_exp[7] = 0;  // JR

        #12;
        check("reset_taken", {31'd0, Taken}, 0);
        check("reset_valid", {31'd0, Taken_valid}, 0);
        check("reset_pcount", Predict_count, 0);
        @(negedge CLK);
        RESET = 1'b1;
        chk_en = 1'b1;

        // 1: first branch from a fresh table
        fetch(I_BEQ, 32'h400, 2'b10);
        check("t1_taken", {31'd0, Taken}, 0);
        check("t1_valid", {31'd0, Taken_valid}, 1);
        check("t1_pcount", Predict_count, 1);
        fetch(I_ADD, 32'h404, 2'b10);
        check("t1_add_valid", {31'd0, Taken_valid}, 0);

        // 2: training and saturation
        resolve(32'h400, 1, 0);
        resolve(32'h400, 1, 0);
        fetch(I_BEQ, 32'h400, 2'b10);
        check("t2_trained", {31'd0, Taken}, 1);
        for (int i = 0; i < 3; i++) resolve(32'h400, 1, 0);
        resolve(32'h400, 0, 0);
        fetch(I_BEQ, 32'h400, 2'b10);
        check("t2_sat_then_dec", {31'd0, Taken}, 1);

        // 3: aliasing and index independence
        fetch(I_BNE, 32'h500, 2'b10);
        check("t3_alias", {31'd0, Taken}, 1);
        fetch(I_BEQ, 32'h404, 2'b10);
        check("t3_other_idx", {31'd0, Taken}, 0);

        // 4: same-cycle train and lookup
        cyc(1, I_BGTZ, 32'h408, 0, 2'b10, 1, 32'h408, 1, 0);
        check("t4_bypass", {31'd0, Taken}, 1);
        check("t4_pcount", Predict_count, 6);

        // 5: static modes, then stall hold with a mode change pending
        fetch(I_BEQ, 32'h400, 2'b00);
        check("t5_mode_nt", {31'd0, Taken}, 0);
        fetch(I_BEQ, 32'h404, 2'b01);
        check("t5_mode_t", {31'd0, Taken}, 1);
        fetch(I_BEQ, 32'h400, 2'b10);
        for (int i = 0; i < 3; i++) cyc(1, I_BEQ, 32'h404, 1, 2'b00, 1, 32'h404, 0, 0);
        check("t5_stall_taken", {31'd0, Taken}, 1);
        check("t5_stall_valid", {31'd0, Taken_valid}, 1);
        check("t5_stall_pcount", Predict_count, 9);

        // decode coverage in always-taken mode
        for (int i = 0; i < 8; i++) begin
            fetch(dec_ins[i], 32'h600 + 32'(i * 4), 2'b01);
            check($sformatf("decode_%0d", i), {31'd0, Taken_valid}, {31'd0, dec_exp[i]});
        end

        // mispredict statistics; mispredict without resolve is ignored
        for (int i = 0; i < 5; i++) resolve(32'h40C, 1, 1);
        cyc(0, I_ADD, 0, 0, 2'b10, 0, 32'h40C, 0, 1);
        check("mis_count", Mispredict_count, 5);

        // 6: asynchronous reset mid-stream
        fetch(I_BEQ, 32'h400, 2'b10);
        check("t6_pre_taken", {31'd0, Taken}, 1);
        #1;
        RESET = 1'b0;
        #1;
        check("t6_rst_taken", {31'd0, Taken}, 0);
        check("t6_rst_mcount", Mispredict_count, 0);
        check("t6_rst_pcount", Predict_count, 0);
        @(negedge CLK);
        RESET = 1'b1;
        fetch(I_BEQ, 32'h400, 2'b10);
        check("t6_after_init", {31'd0, Taken}, 0);
        check("t6_after_valid", {31'd0, Taken_valid}, 1);

        repeat (2) @(negedge CLK);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
